// File: rtl/video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// video_mode_ctrl
//
// Mode detection and configuration for the pixel capture datapath. Counts
// hsync falls per vsync period, classifies each frame (480p, 240p-262,
// 240p-263), qualifies the class over several consecutive frames and then
// drives the capture block's line doubler / add-line selects and its
// visible-area window.
//
// Optional feature macro: VIDEO_MODE_CTRL_LINE_CHECK_EN
//   When defined, a clock-per-line counter also checks every completed line
//   of a frame against LINE_MIN_CLKS..LINE_MAX_CLKS; any out-of-range line
//   makes the frame invalid. When undefined, that logic is not built.
//
// Parameters:
//   STABLE_FRAMES  consecutive identical valid frames needed to lock (2..15)
//   LOSS_FRAMES    consecutive mismatching frames that drop lock (1..15)
//   LINE_MIN_CLKS  minimum clocks per line (line-check build only)
//   LINE_MAX_CLKS  maximum clocks per line (line-check build only)
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   _hsync        active-low hsync, synchronous to clock
//   _vsync        active-low vsync, synchronous to clock
//   line_doubler  1 in both 240p modes
//   add_line      1 in 240p-263
//   hstart/vstart/width/height  visible-area window (10 bits each)
//   mode          0 none, 1 480p, 2 240p-262, 3 240p-263
//   mode_locked   1 while locked
//   mode_changed  one-cycle pulse when the applied configuration changes
//
// State table:
//   UNLOCKED | no candidate; waiting for a valid frame class
//   VERIFY   | candidate class seen, counting identical consecutive frames
//   LOCKED   | class applied; counting consecutive mismatching frames
// ---------------------------------------------------------------------------
module video_mode_ctrl #(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned LOSS_FRAMES   = 2,
    parameter int unsigned LINE_MIN_CLKS = 1000,
    parameter int unsigned LINE_MAX_CLKS = 4000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       _hsync,
    input  logic       _vsync,
    output logic       line_doubler,
    output logic       add_line,
    output logic [9:0] hstart,
    output logic [9:0] vstart,
    output logic [9:0] width,
    output logic [9:0] height,
    output logic [1:0] mode,
    output logic       mode_locked,
    output logic       mode_changed
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_VERIFY   = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [3:0]  STABLE_N     = 4'(STABLE_FRAMES);
    localparam logic [3:0]  LOSS_N       = 4'(LOSS_FRAMES);
    localparam logic [10:0] LINE_SAT     = 11'd2047;
    // Counter value one hsync fall before the 1024-line timeout.
    localparam logic [10:0] LINE_TO_PREV = 11'd1023;

    // Parameter sanity checks at elaboration.
    if (STABLE_FRAMES < 2 || STABLE_FRAMES > 15) begin : g_bad_stable
        $error("video_mode_ctrl: STABLE_FRAMES must be 2..15");
    end
    if (LOSS_FRAMES < 1 || LOSS_FRAMES > 15) begin : g_bad_loss
        $error("video_mode_ctrl: LOSS_FRAMES must be 1..15");
    end
    if (LINE_MIN_CLKS > LINE_MAX_CLKS) begin : g_bad_line_range
        $error("video_mode_ctrl: LINE_MIN_CLKS must not exceed LINE_MAX_CLKS");
    end

    // Window/select bundle: {line_doubler, add_line, hstart, vstart, width, height}
    function automatic logic [41:0] cfg_of(input logic [1:0] cls);
        logic [41:0] cfg;
        case (cls)
            2'd2:    cfg = {1'b1, 1'b0, 10'd327, 10'd18, 10'd643, 10'd504};
            2'd3:    cfg = {1'b1, 1'b1, 10'd347, 10'd18, 10'd643, 10'd504};
            default: cfg = {1'b0, 1'b0, 10'd257, 10'd40, 10'd720, 10'd480};
        endcase
        return cfg;
    endfunction

    // -----------------------------------------------------------------------
    // Sync edge detection and line counting
    // -----------------------------------------------------------------------
    logic        hs_d;
    logic        vs_d;
    logic        hs_fall;
    logic        vs_fall;
    logic [10:0] line_cnt;
    logic [10:0] line_inc;
    logic [10:0] frame_len;
    logic        timeout_hit;
    logic        first_frame;
    logic        frame_bad;
    logic [1:0]  frame_cls;

    // Registered frame events consumed by the FSM one cycle later.
    logic        evt_q;
    logic        to_q;
    logic [1:0]  cls_q;

    assign hs_fall = hs_d & ~_hsync;
    assign vs_fall = vs_d & ~_vsync;

    assign line_inc  = (line_cnt == LINE_SAT) ? line_cnt : line_cnt + 11'd1;
    // An hsync fall coincident with the vsync fall belongs to the closing frame.
    assign frame_len = hs_fall ? line_inc : line_cnt;
    // Fires once, on the hsync fall that takes the count to 1024.
    assign timeout_hit = hs_fall & ~vs_fall & (line_cnt == LINE_TO_PREV);

`ifdef VIDEO_MODE_CTRL_LINE_CHECK_EN
    logic [11:0] clk_cnt;
    logic [12:0] line_clks;
    logic        line_open;
    logic        line_bad;
    logic        line_out;

    // clk_cnt is cleared on the fall, so a line of P clocks ends with P-1.
    assign line_clks = {1'b0, clk_cnt} + 13'd1;
    assign line_out  = hs_fall & line_open &
                       ((line_clks < 13'(LINE_MIN_CLKS)) ||
                        (line_clks > 13'(LINE_MAX_CLKS)));
    assign frame_bad = line_bad | line_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_cnt   <= 12'd0;
            line_open <= 1'b0;
            line_bad  <= 1'b0;
        end else begin
            if (hs_fall) begin
                clk_cnt <= 12'd0;
            end else if (clk_cnt != 12'hfff) begin
                clk_cnt <= clk_cnt + 12'd1;
            end
            // The partial line before a frame's first hsync fall is never checked.
            if (vs_fall) begin
                line_open <= 1'b0;
                line_bad  <= 1'b0;
            end else begin
                if (hs_fall) begin
                    line_open <= 1'b1;
                end
                if (line_out) begin
                    line_bad <= 1'b1;
                end
            end
        end
    end
`else
    assign frame_bad = 1'b0;
`endif

    always_comb begin
        frame_cls = 2'd0;
        if (!frame_bad) begin
            if (frame_len >= 11'd524 && frame_len <= 11'd526) begin
                frame_cls = 2'd1;
            end else if (frame_len == 11'd262) begin
                frame_cls = 2'd2;
            end else if (frame_len == 11'd263) begin
                frame_cls = 2'd3;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            line_cnt    <= 11'd0;
            first_frame <= 1'b1;
            evt_q       <= 1'b0;
            to_q        <= 1'b0;
            cls_q       <= 2'd0;
        end else begin
            hs_d  <= _hsync;
            vs_d  <= _vsync;
            evt_q <= 1'b0;
            to_q  <= timeout_hit;
            if (vs_fall) begin
                line_cnt    <= 11'd0;
                first_frame <= 1'b0;
                // The first vsync fall after reset or timeout only opens a frame.
                evt_q       <= ~first_frame;
                cls_q       <= frame_cls;
            end else begin
                if (hs_fall) begin
                    line_cnt <= line_inc;
                end
                if (timeout_hit) begin
                    first_frame <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Qualification FSM
    // -----------------------------------------------------------------------
    state_t     state_q;
    state_t     state_n;
    logic [1:0] cand_q;
    logic [1:0] cand_n;
    logic [3:0] stable_q;
    logic [3:0] stable_n;
    logic [3:0] stable_inc;
    logic [3:0] miss_q;
    logic [3:0] miss_n;
    logic [3:0] miss_inc;
    logic [1:0] applied_q;
    logic [1:0] mode_n;
    logic       apply_n;
    logic       changed_n;

    assign stable_inc = stable_q + 4'd1;
    assign miss_inc   = miss_q + 4'd1;

    always_comb begin
        state_n   = state_q;
        cand_n    = cand_q;
        stable_n  = stable_q;
        miss_n    = miss_q;
        mode_n    = mode;
        apply_n   = 1'b0;
        changed_n = 1'b0;

        if (to_q) begin
            // Timeout overrides any frame event.
            state_n  = ST_UNLOCKED;
            stable_n = 4'd0;
            miss_n   = 4'd0;
            mode_n   = 2'd0;
        end else if (evt_q) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (cls_q != 2'd0) begin
                        state_n  = ST_VERIFY;
                        cand_n   = cls_q;
                        stable_n = 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (cls_q == 2'd0) begin
                        state_n  = ST_UNLOCKED;
                        stable_n = 4'd0;
                    end else if (cls_q == cand_q) begin
                        if (stable_inc >= STABLE_N) begin
                            state_n   = ST_LOCKED;
                            stable_n  = 4'd0;
                            miss_n    = 4'd0;
                            mode_n    = cls_q;
                            apply_n   = 1'b1;
                            changed_n = (cls_q != applied_q);
                        end else begin
                            stable_n = stable_inc;
                        end
                    end else begin
                        cand_n   = cls_q;
                        stable_n = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (cls_q == mode) begin
                        miss_n = 4'd0;
                    end else if (miss_inc >= LOSS_N) begin
                        // Config registers keep their values after losing lock.
                        state_n = ST_UNLOCKED;
                        miss_n  = 4'd0;
                        mode_n  = 2'd0;
                    end else begin
                        miss_n = miss_inc;
                    end
                end
                default: begin
                    state_n  = ST_UNLOCKED;
                    stable_n = 4'd0;
                    miss_n   = 4'd0;
                    mode_n   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_UNLOCKED;
            cand_q       <= 2'd0;
            stable_q     <= 4'd0;
            miss_q       <= 4'd0;
            mode         <= 2'd0;
            mode_changed <= 1'b0;
            applied_q    <= 2'd1;
            {line_doubler, add_line, hstart, vstart, width, height} <= cfg_of(2'd1);
        end else begin
            state_q      <= state_n;
            cand_q       <= cand_n;
            stable_q     <= stable_n;
            miss_q       <= miss_n;
            mode         <= mode_n;
            mode_changed <= changed_n;
            if (apply_n) begin
                applied_q <= cls_q;
                {line_doubler, add_line, hstart, vstart, width, height} <= cfg_of(cls_q);
            end
        end
    end

    assign mode_locked = (state_q == ST_LOCKED);

endmodule
